// File: rtl/mem_responder.sv
// mem_responder: word RAM plus MMIO window (paced console FIFO, cycle counter,
// exit register) serving the multicycle core's single-port bus.
module mem_responder #(
    parameter int unsigned MEM_WORDS  = 16384,
    parameter string       INIT_FILE  = "",
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TX_DIV     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic [31:0] data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        fault
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_CYC  = 32'h1000_0008;
    localparam logic [31:0] A_EXIT = 32'h1000_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   dropped_q;
    logic [31:0]   cycle_q;
    logic          exit_valid_q;
    logic [31:0]   exit_code_q;
    logic          fault_q;
    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;

    logic ram_sel, sel_tx, sel_stat, sel_cyc, sel_exit, unmapped;
    logic full, empty, push, drop, pop;
    logic unused_addr;

    // address[1:0] is don't-care: every access is a whole word
    assign unused_addr = ^address[1:0];

    // Address decode
    assign ram_sel  = (address[31:AW+2] == '0);
    assign sel_tx   = (address[31:2] == A_TX[31:2]);
    assign sel_stat = (address[31:2] == A_STAT[31:2]);
    assign sel_cyc  = (address[31:2] == A_CYC[31:2]);
    assign sel_exit = (address[31:2] == A_EXIT[31:2]);
    assign unmapped = !(ram_sel || sel_tx || sel_stat || sel_cyc || sel_exit);

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we && ram_sel) begin
            ram_q[address[AW+1:2]] <= data_in;
        end
    end

    // Combinational read mux; RAM shows the pre-write word during a store
    always_comb begin
        data_out = '0;
        if (ram_sel) begin
            data_out = ram_q[address[AW+1:2]];
        end else if (sel_stat) begin
            data_out = {dropped_q, 8'(count_q), 6'b0, empty, full};
        end else if (sel_cyc) begin
            data_out = cycle_q;
        end else if (sel_exit) begin
            data_out = exit_code_q;
        end
    end

    // FIFO push/drop decisions; fullness judged before the edge
    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        push    = we && sel_tx && !full;
        drop    = we && sel_tx && full;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage (data needs no reset; tx_data is gated by tx_valid)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= data_in[7:0];
        end
    end

    // FIFO pointers, counters, exit and fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dropped_q    <= '0;
            cycle_q      <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
            cycle_q <= cycle_q + 32'd1;
            if (we && sel_exit && !exit_valid_q) begin
                exit_valid_q <= 1'b1;
                exit_code_q  <= data_in;
            end
            fault_q <= we && unmapped;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Drain FSM next state; looks at post-edge occupancy so a push is seen at once
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (TX_DIV > 1) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(TX_DIV - 2)) begin
                    state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drain FSM outputs
    always_comb begin
        tx_valid = (state_q == ST_SEND);
        tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;
        pop      = tx_valid && tx_ready;
    end

    assign exit_valid = exit_valid_q;
    assign exit_code  = exit_code_q;
    assign fault      = fault_q;

endmodule
